merlin_mtimer: RTL and testbench

Memory-mapped machine timer target for the merlin32i data bus. It provides a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register and a control register. It drives the core's `irq_timer_i` input, which is the interrupt source directly upstream of the core. It sits on the data port beside the SRAM target, behind external address decode, and uses the same treq/trsp valid/ready handshake.

---
 rtl/merlin_mtimer.sv | 128 ++++++++++++
 tb/tb_merlin_mtimer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merlin_mtimer.sv
// merlin_mtimer: 64-bit mtime/mtimecmp machine timer with CTRL and a level timer irq (prescaler under MERLIN_MTIMER_PRESCALE_EN).
// Latency: read data one cycle after acceptance; irq_timer_o registered one cycle after mtime >= mtimecmp.
// Backpressure: treqready_o = !trspvalid_o || trspready_i; a held response keeps trspdata_o stable.
module merlin_mtimer #(
    parameter logic [63:0] C_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic [31:0] trspdata_o,
    output logic        irq_timer_o
);

    localparam logic [2:0] A_MTIME_LO    = 3'd0;
    localparam logic [2:0] A_MTIME_HI    = 3'd1;
    localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] A_CTRL        = 3'd4;

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic        ctrl_en;
    logic [7:0]  ctrl_pre;
    logic        tick;
    logic [31:0] rdata;
    logic        req_acc;
    logic        rd_acc;
    logic        wr_acc;
    logic        mtime_wr;
    logic [2:0]  idx;
    logic        unused;

    assign treqready_o = !trspvalid_o || trspready_i;
    assign req_acc     = treqvalid_i && treqready_o;
    assign rd_acc      = req_acc && !treqdvalid_i;
    assign wr_acc      = req_acc && treqdvalid_i;
    assign idx         = treqaddr_i[4:2];
    assign mtime_wr    = wr_acc && ((idx == A_MTIME_LO) || (idx == A_MTIME_HI));
    assign unused      = ^{treqaddr_i[31:5], treqaddr_i[1:0], treqdata_i[31:1]};

`ifdef MERLIN_MTIMER_PRESCALE_EN
    logic [7:0] pcnt;

    assign tick = ctrl_en && (pcnt == ctrl_pre);

    // A software write to mtime restarts the prescale period.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pcnt     <= '0;
            ctrl_pre <= '0;
        end else if (clk_en_i) begin
            if (mtime_wr)
                pcnt <= '0;
            else if (ctrl_en)
                pcnt <= tick ? 8'd0 : pcnt + 8'd1;
            if (wr_acc && (idx == A_CTRL))
                ctrl_pre <= treqdata_i[15:8];
        end
    end
`else
    assign tick     = ctrl_en;
    assign ctrl_pre = 8'd0;
`endif

    // Read data reflects register state before this cycle's updates.
    always_comb begin
        rdata = '0;
        case (idx)
            A_MTIME_LO:    rdata = mtime[31:0];
            A_MTIME_HI:    rdata = shadow;
            A_MTIMECMP_LO: rdata = mtimecmp[31:0];
            A_MTIMECMP_HI: rdata = mtimecmp[63:32];
            A_CTRL:        rdata = {16'd0, ctrl_pre, 7'd0, ctrl_en};
            default:       rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mtime       <= '0;
            mtimecmp    <= C_MTIMECMP_RST;
            shadow      <= '0;
            ctrl_en     <= 1'b0;
            irq_timer_o <= 1'b0;
            trspvalid_o <= 1'b0;
            trspdata_o  <= '0;
        end else if (clk_en_i) begin
            irq_timer_o <= ctrl_en && (mtime >= mtimecmp);

            // Software writes take priority over the increment.
            if (mtime_wr) begin
                if (idx == A_MTIME_LO)
                    mtime[31:0] <= treqdata_i;
                else
                    mtime[63:32] <= treqdata_i;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_acc && (idx == A_MTIMECMP_LO))
                mtimecmp[31:0] <= treqdata_i;
            if (wr_acc && (idx == A_MTIMECMP_HI))
                mtimecmp[63:32] <= treqdata_i;
            if (wr_acc && (idx == A_CTRL))
                ctrl_en <= treqdata_i[0];

            // Reading the low word snapshots the high word for a coherent pair.
            if (rd_acc && (idx == A_MTIME_LO))
                shadow <= mtime[63:32];

            if (rd_acc) begin
                trspvalid_o <= 1'b1;
                trspdata_o  <= rdata;
            end else if (trspready_i) begin
                trspvalid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merlin_mtimer.sv
// Bench for merlin_mtimer: directed sequences plus randomized traffic against a time-arithmetic reference model.
module tb_merlin_mtimer;

    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk_i;
    logic        reset_i;
    logic        clk_en_i;
    logic        treqready_o;
    logic        treqvalid_i;
    logic        treqdvalid_i;
    logic [31:0] treqaddr_i;
    logic [31:0] treqdata_i;
    logic        trspready_i;
    logic        trspvalid_o;
    logic [31:0] trspdata_o;
    logic        irq_timer_o;

    int n_chk;
    int n_fail;

    // Reference state: mtime = m_base + (enabled cycles since m_base) / (prescale + 1)
    logic [63:0] m_base;
    logic [63:0] m_ecnt;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic [31:0] m_rdat;
    logic [7:0]  m_pre;
    logic        m_en;
    logic        m_irq;
    logic        m_rvld;

    merlin_mtimer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clk_en_i     (clk_en_i),
        .treqready_o  (treqready_o),
        .treqvalid_i  (treqvalid_i),
        .treqdvalid_i (treqdvalid_i),
        .treqaddr_i   (treqaddr_i),
        .treqdata_i   (treqdata_i),
        .trspready_i  (trspready_i),
        .trspvalid_o  (trspvalid_o),
        .trspdata_o   (trspdata_o),
        .irq_timer_o  (irq_timer_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_time();
        return m_base + m_ecnt / ({56'd0, m_pre} + 64'd1);
    endfunction

    task automatic m_reset();
        m_base   = '0;
        m_ecnt   = '0;
        m_cmp    = CMP_RST;
        m_shadow = '0;
        m_rdat   = '0;
        m_pre    = '0;
        m_en     = 1'b0;
        m_irq    = 1'b0;
        m_rvld   = 1'b0;
    endtask

    task automatic model_update();
        logic [63:0] cur;
        logic [63:0] nt;
        logic        acc;
        logic        rd;
        logic        wr;
        logic [2:0]  ix;
        logic [31:0] rv;
        logic [7:0]  npre;
        if (reset_i) begin
            m_reset();
        end else if (clk_en_i) begin
            cur = m_time();
            acc = treqvalid_i && (!m_rvld || trspready_i);
            rd  = acc && !treqdvalid_i;
            wr  = acc && treqdvalid_i;
            ix  = treqaddr_i[4:2];
            case (ix)
                3'd0:    rv = cur[31:0];
                3'd1:    rv = m_shadow;
                3'd2:    rv = m_cmp[31:0];
                3'd3:    rv = m_cmp[63:32];
                3'd4:    rv = {16'd0, m_pre, 7'd0, m_en};
                default: rv = '0;
            endcase
            m_irq = m_en && (cur >= m_cmp);
            if (rd && ix == 3'd0)
                m_shadow = cur[63:32];
            if (wr && ix == 3'd0) begin
                m_base = {cur[63:32], treqdata_i};
                m_ecnt = '0;
            end else if (wr && ix == 3'd1) begin
                m_base = {treqdata_i, cur[31:0]};
                m_ecnt = '0;
            end else if (m_en) begin
                m_ecnt = m_ecnt + 64'd1;
            end
            if (wr && ix == 3'd2)
                m_cmp[31:0] = treqdata_i;
            if (wr && ix == 3'd3)
                m_cmp[63:32] = treqdata_i;
            if (wr && ix == 3'd4) begin
`ifdef MERLIN_MTIMER_PRESCALE_EN
                npre = treqdata_i[15:8];
`else
                npre = 8'd0;
`endif
                if (npre != m_pre) begin
                    nt     = m_time();
                    m_ecnt = m_ecnt % ({56'd0, m_pre} + 64'd1);
                    m_base = nt;
                    m_pre  = npre;
                end
                m_en = treqdata_i[0];
            end
            if (rd) begin
                m_rvld = 1'b1;
                m_rdat = rv;
            end else if (trspready_i) begin
                m_rvld = 1'b0;
            end
        end
    endtask

    task automatic step();
        #1;
        chk_val("treqready", treqready_o, !m_rvld || trspready_i);
        @(posedge clk_i);
        model_update();
        #1;
        chk_val("trspvalid", trspvalid_o, m_rvld);
        chk_val("trspdata", trspdata_o, m_rdat);
        chk_val("irq", irq_timer_o, m_irq);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic req(input logic is_wr, input logic [2:0] ix, input logic [31:0] d);
        logic [31:0] a;
        a = $urandom;
        a[4:2] = ix;
        treqvalid_i  = 1'b1;
        treqdvalid_i = is_wr;
        treqaddr_i   = a;
        treqdata_i   = d;
        step();
        treqvalid_i  = 1'b0;
        treqdvalid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  ix;
        n_chk        = 0;
        n_fail       = 0;
        reset_i      = 1'b1;
        clk_en_i     = 1'b1;
        treqvalid_i  = 1'b0;
        treqdvalid_i = 1'b0;
        treqaddr_i   = '0;
        treqdata_i   = '0;
        trspready_i  = 1'b1;
        m_reset();
        idle(2);
        reset_i = 1'b0;

        // Reset values visible through reads
        req(1'b0, 3'd4, 32'd0);
        req(1'b0, 3'd2, 32'd0);
        req(1'b0, 3'd0, 32'd0);
        idle(2);

        // Free running, prescale 0
        req(1'b1, 3'd4, 32'h0000_0001);
        idle(10);
        req(1'b0, 3'd0, 32'd0);
        idle(2);

        // Prescale 3 (ignored without the prescaler)
        req(1'b1, 3'd4, 32'h0000_0000);
        req(1'b1, 3'd0, 32'h0000_0000);
        req(1'b1, 3'd4, 32'h0000_0301);
        idle(20);
        req(1'b0, 3'd0, 32'd0);
        idle(2);

        // Carry across the 32-bit boundary with coherent LO/HI pairs
        req(1'b1, 3'd4, 32'h0000_0300);
        req(1'b1, 3'd1, 32'h0000_0000);
        req(1'b1, 3'd0, 32'hFFFF_FFFE);
        req(1'b1, 3'd4, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            req(1'b0, 3'd0, 32'd0);
            req(1'b0, 3'd1, 32'd0);
        end
        idle(2);

        // Compare match raises irq; raising mtimecmp drops it
        req(1'b1, 3'd4, 32'h0000_0000);
        req(1'b1, 3'd1, 32'h0000_0000);
        req(1'b1, 3'd0, 32'h0000_0000);
        req(1'b1, 3'd3, 32'h0000_0000);
        req(1'b1, 3'd2, 32'h0000_0020);
        req(1'b1, 3'd4, 32'h0000_0001);
        idle(40);
        req(1'b1, 3'd2, 32'h0000_0100);
        idle(3);

        // Backpressure stall on back-to-back reads
        trspready_i = 1'b0;
        req(1'b0, 3'd0, 32'd0);
        treqvalid_i  = 1'b1;
        treqdvalid_i = 1'b0;
        a = $urandom;
        a[4:2] = 3'd2;
        treqaddr_i = a;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val("stall_rdy", treqready_o, 1'b0);
            step();
        end
        trspready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            a[4:2] = 3'(i);
            treqaddr_i = a;
            step();
        end
        treqvalid_i = 1'b0;
        idle(2);

        // Randomized traffic with a fixed prescale of 2
        req(1'b1, 3'd4, 32'h0000_0000);
        req(1'b1, 3'd0, 32'h0000_0000);
        req(1'b1, 3'd4, 32'h0000_0201);
        for (int i = 0; i < 400; i++) begin
            clk_en_i     = ($urandom_range(0, 9) != 0);
            trspready_i  = ($urandom_range(0, 3) != 0);
            treqvalid_i  = 1'($urandom_range(0, 1));
            treqdvalid_i = ($urandom_range(0, 2) == 0);
            ix = 3'($urandom_range(0, 7));
            a = $urandom;
            a[4:2] = ix;
            case (ix)
                3'd0:    d = $urandom_range(0, 200);
                3'd1:    d = $urandom_range(0, 1);
                3'd2:    d = $urandom_range(0, 300);
                3'd3:    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
                3'd4: begin
                    d = $urandom;
                    d[15:8] = 8'd2;
                end
                default: d = $urandom;
            endcase
            treqaddr_i = a;
            treqdata_i = d;
            step();
        end
        clk_en_i    = 1'b1;
        trspready_i = 1'b1;
        treqvalid_i = 1'b0;
        idle(3);

        // Reset while a response is pending and the counter runs
        req(1'b1, 3'd4, 32'h0000_0001);
        trspready_i = 1'b0;
        req(1'b0, 3'd0, 32'd0);
        idle(2);
        reset_i = 1'b1;
        step();
        reset_i     = 1'b0;
        trspready_i = 1'b1;
        idle(3);
        req(1'b0, 3'd2, 32'd0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
